// File: rtl/input_conditioner.sv
// input_conditioner: board-input front end for the Minilab0 top level.
// Synchronizes the active-low KEY buttons and SW slide switches into the
// CLOCK_50 domain, debounces every key with its own four-state FSM and emits
// clean levels plus single-cycle press/release/switch-change pulses.
//
// Optional feature macro: INPUT_COND_SW_DEBOUNCE_EN
//   defined   -> each switch is debounced by the same FSM as the keys
//   undefined -> switches are synchronizer-only (no switch FSM/counter)
//
// Ports:
//   CLOCK_50     in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   key_raw      in   raw buttons, 0 = pressed, asynchronous
//   sw_raw       in   raw switches, 1 = up, asynchronous
//   key_level    out  debounced key state, 1 = pressed
//   key_press    out  one-cycle pulse when key_level rises
//   key_release  out  one-cycle pulse when key_level falls
//   sw_sync      out  synchronized (optionally debounced) switch levels
//   sw_change    out  one-cycle pulse when any sw_sync bit changes

// Single-channel debouncer: qualifies an active-high synchronized input and
// produces a registered level plus registered rise/fall pulses.
module input_conditioner_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_s,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic             w_level_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RELEASED;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Next-state, counter and pulse decode; counter stops at CNT_LAST so it never wraps
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_level_nxt = 1'b0;

    case (r_state)
      RELEASED: begin
        if (i_s) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!i_s) begin
          w_state_nxt = RELEASED;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = PRESSED;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!i_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (i_s) begin
          w_state_nxt = PRESSED;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = RELEASED;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = RELEASED;
      end
    endcase

    // Level follows the state being entered so it moves with the pulse
    w_level_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == RELEASE_WAIT);
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

module input_conditioner #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned NUM_SW          = 10,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                CLOCK_50,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic [NUM_SW-1:0]   sw_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_SW-1:0]   sw_sync,
  output logic                sw_change
);

  logic [NUM_KEYS-1:0] r_key_sync [SYNC_STAGES];
  logic [NUM_SW-1:0]   r_sw_sync  [SYNC_STAGES];
  logic [NUM_KEYS-1:0] w_key_s;
  logic [NUM_SW-1:0]   w_sw_s;
  logic [NUM_SW-1:0]   r_sw_prev;
  logic                r_sw_change;

  // Key synchronizer; resets to all-ones so keys start released
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_key_sync[i] <= '1;
    end else begin
      r_key_sync[0] <= key_raw;
      for (int i = 1; i < SYNC_STAGES; i++) r_key_sync[i] <= r_key_sync[i-1];
    end
  end

  // Switch synchronizer; resets to all-zeros
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sw_sync[i] <= '0;
    end else begin
      r_sw_sync[0] <= sw_raw;
      for (int i = 1; i < SYNC_STAGES; i++) r_sw_sync[i] <= r_sw_sync[i-1];
    end
  end

  // Buttons are active-low on the board; debounce in active-high form
  assign w_key_s = ~r_key_sync[SYNC_STAGES-1];
  assign w_sw_s  = r_sw_sync[SYNC_STAGES-1];

  // One independent debouncer per key
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    input_conditioner_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_key_db (
      .clk     (CLOCK_50),
      .rst_n   (rst_n),
      .i_s     (w_key_s[g]),
      .o_level (key_level[g]),
      .o_rise  (key_press[g]),
      .o_fall  (key_release[g])
    );
  end

`ifdef INPUT_COND_SW_DEBOUNCE_EN
  // Switch edge pulses are not needed; sw_change comes from the levels
  logic [NUM_SW-1:0] w_sw_rise_unused;
  logic [NUM_SW-1:0] w_sw_fall_unused;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
    input_conditioner_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_sw_db (
      .clk     (CLOCK_50),
      .rst_n   (rst_n),
      .i_s     (w_sw_s[g]),
      .o_level (sw_sync[g]),
      .o_rise  (w_sw_rise_unused[g]),
      .o_fall  (w_sw_fall_unused[g])
    );
  end
`else
  assign sw_sync = w_sw_s;
`endif

  // Change detector on the published switch levels
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_prev   <= '0;
      r_sw_change <= 1'b0;
    end else begin
      r_sw_prev   <= sw_sync;
      r_sw_change <= |(sw_sync ^ r_sw_prev);
    end
  end

  assign sw_change = r_sw_change;

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  localparam int unsigned NK = 4;
  localparam int unsigned NS = 10;
  localparam int KEY_LAT = 6;
`ifdef INPUT_COND_SW_DEBOUNCE_EN
  localparam int SW_LAT = 6;
`else
  localparam int SW_LAT = 2;
`endif

  typedef struct {
    int          cyc;
    logic [3:0]  press;
    logic [3:0]  rel;
    logic [3:0]  level;
    logic [9:0]  sw;
    logic        chg;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [NK-1:0] key_raw;
  logic [NS-1:0] sw_raw;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NS-1:0] sw_sync;
  logic          sw_change;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  input_conditioner #(
    .NUM_KEYS        (4),
    .NUM_SW          (10),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .CLOCK_50    (clk),
    .rst_n       (rst_n),
    .key_raw     (key_raw),
    .sw_raw      (sw_raw),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .sw_sync     (sw_sync),
    .sw_change   (sw_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int dly, input logic [3:0] press, input logic [3:0] rel,
                      input logic [3:0] level, input logic [9:0] sw, input logic chg);
    exp_t e;
    e.cyc = cyc + dly; e.press = press; e.rel = rel;
    e.level = level; e.sw = sw; e.chg = chg;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every pulse the DUT presents must match the next expected event
  always @(negedge clk) begin
    if (rst_n && ((key_press | key_release) != '0 || sw_change)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: cyc %0d press=%b rel=%b chg=%b, expected no pulse",
                 cyc, key_press, key_release, sw_change);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (cyc != e.cyc || key_press !== e.press || key_release !== e.rel ||
            key_level !== e.level || sw_sync !== e.sw || sw_change !== e.chg) begin
          n_bad++;
          $display("FAIL event: got cyc=%0d press=%b rel=%b level=%b sw=%h chg=%b, expected cyc=%0d press=%b rel=%b level=%b sw=%h chg=%b",
                   cyc, key_press, key_release, key_level, sw_sync, sw_change,
                   e.cyc, e.press, e.rel, e.level, e.sw, e.chg);
        end
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    key_raw = 4'hF;
    sw_raw  = '0;

    // Reset state
    #1;
    chk("rst_key_level",   32'(key_level),   32'h0);
    chk("rst_key_press",   32'(key_press),   32'h0);
    chk("rst_key_release", 32'(key_release), 32'h0);
    chk("rst_sw_sync",     32'(sw_sync),     32'h0);
    chk("rst_sw_change",   32'(sw_change),   32'h0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(10);
    chk("idle_key_level", 32'(key_level), 32'h0);
    chk("idle_sw_sync",   32'(sw_sync),   32'h0);

    // Single key press and release
    key_raw[0] = 1'b0;
    push(KEY_LAT, 4'b0001, 4'b0000, 4'b0001, 10'h000, 1'b0);
    wait_cyc(10);
    key_raw[0] = 1'b1;
    push(KEY_LAT, 4'b0000, 4'b0001, 4'b0000, 10'h000, 1'b0);
    wait_cyc(10);

    // Bounce shorter than the debounce window is rejected
    key_raw[1] = 1'b0; wait_cyc(1);
    key_raw[1] = 1'b1; wait_cyc(1);
    key_raw[1] = 1'b0; wait_cyc(1);
    key_raw[1] = 1'b1;
    wait_cyc(12);
    chk("bounce_key_level", 32'(key_level), 32'h0);

    // Two keys pressed on the same edge, then only key 2 released
    key_raw[3:2] = 2'b00;
    push(KEY_LAT, 4'b1100, 4'b0000, 4'b1100, 10'h000, 1'b0);
    wait_cyc(10);
    key_raw[2] = 1'b1;
    push(KEY_LAT, 4'b0000, 4'b0100, 4'b1000, 10'h000, 1'b0);
    wait_cyc(10);

    // Switch pattern up, then back down
    sw_raw = 10'h2A5;
    push(SW_LAT + 1, 4'b0000, 4'b0000, 4'b1000, 10'h2A5, 1'b1);
    wait_cyc(SW_LAT - 1);
    chk("sw_sync_before", 32'(sw_sync), 32'h000);
    wait_cyc(1);
    chk("sw_sync_after", 32'(sw_sync), 32'h2A5);
    wait_cyc(10);
    sw_raw = 10'h000;
    push(SW_LAT + 1, 4'b0000, 4'b0000, 4'b1000, 10'h000, 1'b1);
    wait_cyc(12);

    // Reset in the middle of qualifying key 0 while key 3 is held pressed
    key_raw[0] = 1'b0;
    wait_cyc(5);
    chk("pre_reset_level", 32'(key_level), 32'h8);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_level", 32'(key_level), 32'h0);
    chk("mid_reset_press", 32'(key_press), 32'h0);
    wait_cyc(2);
    rst_n = 1'b1;
    push(KEY_LAT, 4'b1001, 4'b0000, 4'b1001, 10'h000, 1'b0);
    wait_cyc(10);
    key_raw = 4'hF;
    push(KEY_LAT, 4'b0000, 4'b1001, 4'b0000, 10'h000, 1'b0);
    wait_cyc(12);

    chk("pending_events", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Board-input front end for the Minilab0 top level. It synchronizes the raw active-low KEY buttons and the SW slide switches into the CLOCK_50 domain and debounces each key with its own state machine. It emits clean levels plus single-cycle press, release and switch-change pulses for the downstream FIFO/MAC control and display logic.

## Interface

Parameters:
- NUM_KEYS, 4, number of push-buttons
- NUM_SW, 10, number of slide switches
- SYNC_STAGES, 2, synchronizer flop depth; legal range 2..4
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a key change; legal range 2..65535
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived)

Ports:
- CLOCK_50  input  1  system clock, all flops on rising edge
- rst_n  input  1  asynchronous active-low reset
- key_raw  input  NUM_KEYS  raw buttons, 0 = pressed, asynchronous
- sw_raw  input  NUM_SW  raw switches, 1 = up, asynchronous
- key_level  output  NUM_KEYS  debounced state, 1 = pressed
- key_press  output  NUM_KEYS  one-cycle pulse when key_level rises
- key_release  output  NUM_KEYS  one-cycle pulse when key_level falls
- sw_sync  output  NUM_SW  synchronized (optionally debounced) switch levels
- sw_change  output  1  one-cycle pulse when any sw_sync bit changes

## Operation

- Per-key pipeline: SYNC_STAGES-flop synchronizer, inverted to active-high `s`, then FSM plus CNT_W counter.
- FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- RELEASED:
  - s=1: go to PRESS_WAIT, cnt=1.
  - Otherwise hold, cnt=0.
- PRESS_WAIT:
  - s=0: return to RELEASED, cnt=0 (bounce rejected, no pulse).
  - Else if cnt==DEBOUNCE_CYCLES-1: go to PRESSED, cnt=0, key_press=1 for one cycle.
  - Else: cnt+1.
- PRESSED:
  - s=0: go to RELEASE_WAIT, cnt=1.
- RELEASE_WAIT:
  - s=1: return to PRESSED, cnt=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: go to RELEASED, key_release=1 for one cycle.
  - Else: cnt+1.
- key_level is 1 in PRESSED and RELEASE_WAIT, 0 otherwise. It is registered and changes on the same edge as the corresponding pulse.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.
- Keys are fully independent. Any combination may press or release on the same edge, and each gets its own pulse.
- Switches: SYNC_STAGES synchronizer only, unless the macro below is defined.
  - sw_prev register holds the previous sw_sync.
  - sw_change = |(sw_sync ^ sw_prev), registered.

## Timing

- Reset values:
  - Key synchronizer flops 1 (released); switch synchronizer flops 0.
  - All FSMs RELEASED, cnt=0.
  - key_level, key_press, key_release, sw_sync, sw_change all 0; sw_prev 0.
- Reset is asynchronous mid-operation: outputs drop immediately and any pulse in flight is lost. After deassertion, a key still held is re-qualified from RELEASED.
- Key press latency: with the first edge sampling key_raw=0 counted as edge 1, key_level and key_press assert after edge SYNC_STAGES+DEBOUNCE_CYCLES. Default: edge 18; with SYNC_STAGES=2, DEBOUNCE_CYCLES=4: edge 6. Release latency is identical.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no level change and no pulse.
- Switch latency: sw_sync follows sw_raw after SYNC_STAGES edges. sw_change asserts one edge after sw_sync changes, for exactly one cycle per change edge.
- Switches high at reset release cause one sw_change pulse; this is intended.

## Configuration

- Macro INPUT_COND_SW_DEBOUNCE_EN.
- Defined:
  - Each switch gets the same four-state FSM and DEBOUNCE_CYCLES counter.
  - sw_sync carries the debounced level; switch latency equals key latency.
  - sw_change is derived from the debounced levels.
- Undefined: switches are synchronizer-only and no switch FSM or counter logic is generated.

## Test plan

All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, 10 ns clock.
- Reset with key_raw=4'hF, sw_raw=0 -> all outputs 0; hold 10 cycles, no pulses.
- key_raw[0] driven 0 and held -> key_level[0]=1 and one-cycle key_press[0] at edge 6. Release -> key_release[0] at edge 6 after the release; key_level[0]=0.
- key_raw[1] bounces 0,1,0,1 (one cycle each), then stays 1 -> key_level[1] stays 0 with no press or release pulses.
- key_raw[3:2] driven 0 on the same edge -> key_press[3] and key_press[2] pulse on the same edge 6.
- sw_raw 10'h000 -> 10'h2A5 -> sw_sync=10'h2A5 after 2 edges; sw_change is one pulse on the next edge. Repeat with the macro defined -> sw_sync updates at edge 6.
- key_raw[0]=0 held, rst_n pulsed low at cycle 3 of PRESS_WAIT -> outputs 0 immediately. After release of reset, key_press[0] fires at edge 6 counted from the first post-reset edge.
